aes_key_expander: RTL
=====================

Name: aes_key_expander

Overview:
- Sequential AES key-schedule engine and successor to the single-round combinational key generator.
- Runtime-selectable AES-128/192/256; generates one 32-bit schedule word per cycle and stores the full schedule (up to 60 words).
- Serves any round key by index to the cipher datapath, removing the per-round combinational key chain.
- Sits beside the round pipeline; loaded once per key, read many times.

Parameters:
- MAX_KEY_BITS, 256, largest supported key (128/192/256); sizes storage to 4*(Nr_max+1) words; larger modes rejected.
- RK_OUT_REG, 1, 1 = round key registered (1-cycle read latency); 0 = combinational read.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin expansion; sampled only in IDLE or DONE
- key_size  in  2  00=128, 01=192, 10=256, 11=illegal
- key_in  in  [0:255]  key, byte 0 at bits [0:7]; 128/192-bit keys use [0:127]/[0:191]
- busy  out  1  expansion in progress
- ready  out  1  schedule complete and readable
- err  out  1  one-cycle pulse: start rejected
- rk_idx  in  4  round-key index 0..Nr
- rk_out  out  [0:127]  round key rk_idx, word w[4*idx] at bits [0:31]

Behaviour:
- Reset: busy=0, ready=0, err=0, rk_out=0, FSM=IDLE, rcon=8'h01, counters=0. Storage is not reset (see optional feature).
- Nk/Nr: 4/10, 6/12, 8/14. Total words = 4*(Nr+1): 44, 52, 60.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE with start=1 and legal mode:
  - write w[0..Nk-1] from key_in; latch Nk/Nr; rcon<=01; i<=Nk; go to EXPAND.
  - ready drops the next cycle.
- Illegal start (key_size=11, or mode above MAX_KEY_BITS): err=1 for one cycle; state and contents unchanged.
- EXPAND: each cycle compute w[i] = w[i-Nk] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod Nk == 0; rcon then advances by xtime (GF(2^8), poly 0x11B).
  - t = SubWord(w[i-1]) when Nk==8 and i mod Nk == 4.
  - t = w[i-1] otherwise.
  - i mod Nk is tracked by a wrapping counter (no divider).
- After the last word (i = total-1): go to DONE; ready=1, busy=0.
- Latency from the start cycle T: ready rises at T+41 (128), T+47 (192), T+53 (256).
- start while busy is ignored (no err).
- Read:
  - With RK_OUT_REG=1, rk_out updates the cycle after rk_idx and only while ready.
  - rk_idx > Nr returns 0.
  - rk_out holds its last value when not ready.
- Reset mid-EXPAND: returns to IDLE within one cycle; ready stays 0; partial schedule is discarded and must not be read.

Optional Feature:
- Macro: KEXP_ZEROIZE_EN.
- Defined: adds input zeroize (1 bit).
  - When high, all storage words, rk_out, rcon and counters clear to 0 in one cycle and the FSM goes to IDLE.
  - Has priority over start; rst_n also zeroes storage.
- Undefined: no zeroize port; storage is never cleared.

Decomposition:
- Shared package aes_pkg holds:
  - key_size_t enum
  - NK/NR lookup functions
  - xtime function
  - RCON_INIT constant
  - word_t (logic [0:31])
  - MAX_WORDS derived constant
- One sub-module, aes_subword: four instances of the existing S-box applied to a 32-bit word, combinational.
- RotWord is a byte rotate in the parent.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - ready at T+41.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - ready at T+47.
  - rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - ready at T+53.
  - rk_idx=14 -> fe4890d1e6188d0b046df344706c631e.
- Illegal start:
  - key_size=11 -> err pulse, ready unchanged.
  - MAX_KEY_BITS=128 build with key_size=10 -> err.
  - start during EXPAND -> ignored; final keys still match the first key.
- Reset mid-operation:
  - rst_n=0 at T+20 -> busy=0, ready=0 next cycle.
  - New AES-128 start -> correct round-10 key.
  - rk_idx=11 in 128 mode -> rk_out=0.
- Optional feature (KEXP_ZEROIZE_EN defined): zeroize in DONE -> ready=0, rk_out=0; after a restart, round-0 key equals key_in.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-size encoding, FSM state type,
// Nk/Nr lookups, GF(2^8) xtime, Rcon seed, schedule word type and S-box.
// Words and keys use ascending bit order: byte 0 sits at bits [0:7].
package aes_pkg;

    typedef logic [0:31] word_t;

    typedef enum logic [1:0] {
        KS_128     = 2'b00,
        KS_192     = 2'b01,
        KS_256     = 2'b10,
        KS_ILLEGAL = 2'b11
    } key_size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } kexp_state_t;

    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam int unsigned MAX_WORDS = 4 * (14 + 1);

    function automatic logic [3:0] nk_of(input key_size_t ks);
        case (ks)
            KS_128:  return 4'd4;
            KS_192:  return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_size_t ks);
        return nk_of(ks) + 4'd6;
    endfunction

    function automatic int unsigned key_bits(input key_size_t ks);
        return 128 + 64 * int'(ks);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box, entry n at bits [8n:8n+7].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Cipher-side bus of the key expander.
//   master: start, key_size, key_in, rk_idx (+ zeroize) out; busy, ready, err, rk_out in
//   slave : the mirror image, used by aes_key_expander
// With KEXP_ZEROIZE_EN defined the bus carries an extra zeroize request.
interface aes_key_expander_if;
    logic         start;
    logic [1:0]   key_size;
    logic [0:255] key_in;
    logic         busy;
    logic         ready;
    logic         err;
    logic [3:0]   rk_idx;
    logic [0:127] rk_out;
`ifdef KEXP_ZEROIZE_EN
    logic         zeroize;
`endif

    modport master (
`ifdef KEXP_ZEROIZE_EN
        output zeroize,
`endif
        output start, key_size, key_in, rk_idx,
        input  busy, ready, err, rk_out
    );

    modport slave (
`ifdef KEXP_ZEROIZE_EN
        input  zeroize,
`endif
        input  start, key_size, key_in, rk_idx,
        output busy, ready, err, rk_out
    );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four forward S-boxes applied byte-wise to a 32-bit word.
//   aes_sbox   : a_i (byte) -> s_o (substituted byte)
//   aes_subword: w_i (word) -> w_o (SubWord(w_i)), purely combinational
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    assign s_o = sbox(a_i);
endmodule

module aes_subword
    import aes_pkg::*;
(
    input  word_t w_i,
    output word_t w_o
);
    for (genvar g = 0; g < 4; g++) begin : g_byte
        aes_sbox u_sbox (
            .a_i (w_i[8*g +: 8]),
            .s_o (w_o[8*g +: 8])
        );
    end
endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule. Expands one word per cycle into
// local storage, then serves round key rk_idx as {w[4i], .., w[4i+3]}.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : aes_key_expander_if.slave (start/key_size/key_in/rk_idx in;
//                busy/ready/err/rk_out out)
// Optional: KEXP_ZEROIZE_EN adds bus.zeroize, clearing storage, rk_out, rcon
// and counters in one cycle; rst_n then also clears storage.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter bit          RK_OUT_REG   = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    aes_key_expander_if.slave bus
);
    localparam int unsigned MAX_NK      = MAX_KEY_BITS / 32;
    localparam int unsigned STORE_WORDS = 4 * (MAX_NK + 7);

    kexp_state_t  state_q, state_d;
    logic [5:0]   i_q, i_d;
    logic [2:0]   mod_q, mod_d;    // i mod Nk, wraps at Nk-1
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   nk_q, nk_d;
    logic [3:0]   nr_q, nr_d;
    logic         err_q, err_d;
    logic [0:127] rk_q, rk_d;
    word_t        w_q [STORE_WORDS];

    key_size_t    ks;
    logic         start_legal;
    logic         load_key, wr_en, clr;
    word_t        prev_w, old_w, rot_w, sub_in, sub_out, temp_w, new_w;
    logic [5:0]   last_idx, rd_base;
    logic [0:127] rd_key;

`ifdef KEXP_ZEROIZE_EN
    assign clr = bus.zeroize;
`else
    assign clr = 1'b0;
`endif

    assign ks          = key_size_t'(bus.key_size);
    assign start_legal = (ks != KS_ILLEGAL) && (key_bits(ks) <= MAX_KEY_BITS);
    assign last_idx    = {nr_q, 2'b00} + 6'd3;

    assign prev_w = w_q[i_q - 6'd1];
    assign old_w  = w_q[i_q - 6'(nk_q)];
    assign rot_w  = {prev_w[8:31], prev_w[0:7]};
    assign sub_in = (mod_q == '0) ? rot_w : prev_w;

    aes_subword u_subword (
        .w_i (sub_in),
        .w_o (sub_out)
    );

    always_comb begin
        temp_w = prev_w;
        if (mod_q == '0)
            temp_w = sub_out ^ {rcon_q, 24'h000000};
        else if ((nk_q == 4'd8) && (mod_q == 3'd4))
            temp_w = sub_out;
    end
    assign new_w = old_w ^ temp_w;

    assign rd_base = {bus.rk_idx, 2'b00};
    always_comb begin
        rd_key = '0;
        if (bus.rk_idx <= nr_q)
            rd_key = {w_q[rd_base], w_q[rd_base + 6'd1],
                      w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        mod_d    = mod_q;
        rcon_d   = rcon_q;
        nk_d     = nk_q;
        nr_d     = nr_q;
        err_d    = 1'b0;
        rk_d     = rk_q;
        load_key = 1'b0;
        wr_en    = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            i_d     = '0;
            mod_d   = '0;
            rcon_d  = '0;
            nk_d    = '0;
            nr_d    = '0;
            rk_d    = '0;
        end else begin
            // Read port follows rk_idx only while the schedule is complete.
            if (state_q == ST_DONE)
                rk_d = rd_key;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (start_legal) begin
                            load_key = 1'b1;
                            nk_d     = nk_of(ks);
                            nr_d     = nr_of(ks);
                            rcon_d   = RCON_INIT;
                            i_d      = 6'(nk_of(ks));
                            mod_d    = '0;
                            state_d  = ST_EXPAND;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_EXPAND: begin
                    wr_en = 1'b1;
                    i_d   = i_q + 6'd1;
                    mod_d = ({1'b0, mod_q} == nk_q - 4'd1) ? '0 : mod_q + 3'd1;
                    if (mod_q == '0)
                        rcon_d = xtime(rcon_q);
                    if (i_q == last_idx)
                        state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            mod_q   <= '0;
            rcon_q  <= RCON_INIT;
            nk_q    <= '0;
            nr_q    <= '0;
            err_q   <= 1'b0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mod_q   <= mod_d;
            rcon_q  <= rcon_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
            rk_q    <= rk_d;
        end
    end

    always_ff @(posedge clk) begin
`ifdef KEXP_ZEROIZE_EN
        if (!rst_n || clr) begin
            for (int unsigned j = 0; j < STORE_WORDS; j++)
                w_q[j] <= '0;
        end else
`endif
        if (load_key) begin
            for (int unsigned j = 0; j < MAX_NK; j++)
                if (j < 32'(nk_of(ks)))
                    w_q[j] <= bus.key_in[32*j +: 32];
        end else if (wr_en) begin
            w_q[i_q] <= new_w;
        end
    end

    assign bus.busy   = (state_q == ST_EXPAND);
    assign bus.ready  = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.rk_out = (RK_OUT_REG || (state_q != ST_DONE)) ? rk_q : rd_key;

endmodule
